ex_muldiv: RTL and testbench

Iterative integer multiply/divide unit in the EX stage. It consumes the ID/EX latch outputs: read_data_1/2 as operands and function code as the operation select. It owns the architectural HI/LO registers and serves MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO. It raises a stall request to the hazard unit while a long operation is pending, so the front end and ID/EX latch hold.

---
 rtl/ex_muldiv_pkg.sv | 34 +++
 rtl/muldiv_div_step.sv | 24 ++
 rtl/ex_muldiv.sv | 181 ++++++++++++++++++
 tb/tb_ex_muldiv.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared constants for the EX-stage multiply/divide unit: funct codes,
// iteration count and the 2-bit controller state encoding.
package ex_muldiv_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    localparam int MULDIV_ITERATIONS = 32;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    function automatic logic is_start(input logic [5:0] funct);
        return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
               (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
    endfunction

    // Every funct that touches HI/LO must wait for a pending operation.
    function automatic logic is_muldiv(input logic [5:0] funct);
        return is_start(funct) ||
               (funct == FUNCT_MFHI) || (funct == FUNCT_MTHI) ||
               (funct == FUNCT_MFLO) || (funct == FUNCT_MTLO);
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-divide iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, shift in a quotient bit.
module muldiv_div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_rem,
    input  logic [W-1:0] i_quo,
    input  logic [W-1:0] i_div,
    output logic [W-1:0] o_rem,
    output logic [W-1:0] o_quo
);

    logic [W:0]   w_shift;
    logic [W-1:0] w_diff;
    logic         w_ge;

    assign w_shift = {i_rem, i_quo[W-1]};
    assign w_ge    = (w_shift >= {1'b0, i_div});
    // When the subtraction is taken the result is below the divisor, so W bits hold it.
    assign w_diff  = w_shift[W-1:0] - i_div;
    assign o_rem   = w_ge ? w_diff : w_shift[W-1:0];
    assign o_quo   = {i_quo[W-2:0], w_ge};

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative MULT/DIV unit owning HI/LO; requests a pipeline stall
// while busy. Build option MULDIV_FAST_MUL_EN: single-cycle multiply.
//
// state   | meaning
// MD_IDLE | no operation pending, MT/MF ops served directly
// MD_RUN  | one multiply or divide bit per cycle on magnitudes
// MD_FIX  | sign correction, HI/LO written on the exiting edge
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ITER_W     = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid,
    input  logic [5:0]            function_in,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    output logic                  busy,
    output logic                  stall_req,
    output logic [DATA_WIDTH-1:0] result_out,
    output logic [DATA_WIDTH-1:0] hi_out,
    output logic [DATA_WIDTH-1:0] lo_out
);

    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(MULDIV_ITERATIONS - 1);

    md_state_e             r_state;
    md_state_e             w_state_nxt;
    logic [ITER_W-1:0]     r_cnt;
    logic [DATA_WIDTH-1:0] r_hi;
    logic [DATA_WIDTH-1:0] r_lo;
    logic [DATA_WIDTH-1:0] r_acc_hi;
    logic [DATA_WIDTH-1:0] r_acc_lo;
    logic [DATA_WIDTH-1:0] r_opb;
    logic                  r_neg_a;
    logic                  r_neg_b;
    logic                  r_is_div;
    logic                  r_dbz;

    logic                    w_busy;
    logic                    w_start;
    logic                    w_direct_fix;
    logic                    w_is_div_op;
    logic                    w_signed;
    logic                    w_neg_a;
    logic                    w_neg_b;
    logic [DATA_WIDTH-1:0]   w_abs_a;
    logic [DATA_WIDTH-1:0]   w_abs_b;
    logic [DATA_WIDTH-1:0]   w_rem_nxt;
    logic [DATA_WIDTH-1:0]   w_quo_nxt;
    logic [DATA_WIDTH-1:0]   w_quo_fix;
    logic [DATA_WIDTH-1:0]   w_rem_fix;
    logic [DATA_WIDTH:0]     w_mul_sum;
    logic [2*DATA_WIDTH-1:0] w_prod_fix;

    assign w_busy      = (r_state != MD_IDLE);
    assign w_start     = op_valid && !w_busy && is_start(function_in);
    assign w_is_div_op = (function_in == FUNCT_DIV) || (function_in == FUNCT_DIVU);
    assign w_signed    = (function_in == FUNCT_MULT) || (function_in == FUNCT_DIV);
    assign w_neg_a     = w_signed && operand_a[DATA_WIDTH-1];
    assign w_neg_b     = w_signed && operand_b[DATA_WIDTH-1];
    assign w_abs_a     = w_neg_a ? -operand_a : operand_a;
    assign w_abs_b     = w_neg_b ? -operand_b : operand_b;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*DATA_WIDTH-1:0] w_fast_prod;
    assign w_direct_fix = !w_is_div_op;
    assign w_fast_prod  = {{DATA_WIDTH{1'b0}}, w_abs_a} * {{DATA_WIDTH{1'b0}}, w_abs_b};
`else
    assign w_direct_fix = 1'b0;
`endif

    muldiv_div_step #(.W(DATA_WIDTH)) u_div_step (
        .i_rem (r_acc_hi),
        .i_quo (r_acc_lo),
        .i_div (r_opb),
        .o_rem (w_rem_nxt),
        .o_quo (w_quo_nxt)
    );

    // Shift-add: the multiplier sits in acc_lo and drains out of bit 0 as the product fills in.
    assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opb} : '0);

    assign w_prod_fix = (r_neg_a ^ r_neg_b) ? -{r_acc_hi, r_acc_lo} : {r_acc_hi, r_acc_lo};
    // Divide by zero leaves |a| as remainder, so the dividend-sign fix restores a itself.
    assign w_quo_fix  = r_dbz ? '1 : ((r_neg_a ^ r_neg_b) ? -r_acc_lo : r_acc_lo);
    assign w_rem_fix  = r_neg_a ? -r_acc_hi : r_acc_hi;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MD_IDLE: if (w_start) w_state_nxt = w_direct_fix ? MD_FIX : MD_RUN;
            MD_RUN:  if (r_cnt == LAST_ITER) w_state_nxt = MD_FIX;
            MD_FIX:  w_state_nxt = MD_IDLE;
            default: w_state_nxt = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_opb    <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_is_div <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (w_start) begin
                        r_cnt    <= '0;
                        r_opb    <= w_abs_b;
                        r_neg_a  <= w_neg_a;
                        r_neg_b  <= w_neg_b;
                        r_is_div <= w_is_div_op;
                        r_dbz    <= (operand_b == '0);
                        r_acc_hi <= '0;
                        r_acc_lo <= w_abs_a;
`ifdef MULDIV_FAST_MUL_EN
                        if (!w_is_div_op) begin
                            {r_acc_hi, r_acc_lo} <= w_fast_prod;
                        end
`endif
                    end else if (op_valid && function_in == FUNCT_MTHI) begin
                        r_hi <= operand_a;
                    end else if (op_valid && function_in == FUNCT_MTLO) begin
                        r_lo <= operand_a;
                    end
                end
                MD_RUN: begin
                    r_cnt <= r_cnt + ITER_W'(1);
                    if (r_is_div) begin
                        r_acc_hi <= w_rem_nxt;
                        r_acc_lo <= w_quo_nxt;
                    end else begin
                        r_acc_hi <= w_mul_sum[DATA_WIDTH:1];
                        r_acc_lo <= {w_mul_sum[0], r_acc_lo[DATA_WIDTH-1:1]};
                    end
                end
                MD_FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        result_out = '0;
        if (op_valid && function_in == FUNCT_MFHI) begin
            result_out = r_hi;
        end else if (op_valid && function_in == FUNCT_MFLO) begin
            result_out = r_lo;
        end
    end

    assign busy      = w_busy;
    assign stall_req = op_valid && w_busy && is_muldiv(function_in);
    assign hi_out    = r_hi;
    assign lo_out    = r_lo;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: vector table of MULT/DIV results and latency,
// plus hand sequences for MT/MF, interlock, busy-time starts and async reset.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [5:0]  function_in;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        stall_req;
    logic [31:0] result_out;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_CYC = 1;
`else
    localparam int MUL_CYC = 33;
`endif
    localparam int DIV_CYC = 33;

    typedef struct {
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       name;
    } vec_t;

    vec_t vecs[14];

    ex_muldiv dut (
        .clk         (clk),
        .reset       (reset),
        .op_valid    (op_valid),
        .function_in (function_in),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .busy        (busy),
        .stall_req   (stall_req),
        .result_out  (result_out),
        .hi_out      (hi_out),
        .lo_out      (lo_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op_valid    = 1'b1;
        function_in = f;
        operand_a   = a;
        operand_b   = b;
        @(posedge clk);
        #1;
        op_valid    = 1'b0;
        function_in = F_ADD;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        @(negedge clk);
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;

        vecs[0]  = '{F_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, MUL_CYC, "mult_m2x3"};
        vecs[1]  = '{F_MULTU, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, MUL_CYC, "multu_fffe_x3"};
        vecs[2]  = '{F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_CYC, "div_m7_2"};
        vecs[3]  = '{F_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, DIV_CYC, "divu_7_2"};
        vecs[4]  = '{F_DIV,   32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, DIV_CYC, "div_by_zero"};
        vecs[5]  = '{F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_CYC, "div_overflow"};
        vecs[6]  = '{F_MULT,  32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A, MUL_CYC, "mult_6x7"};
        vecs[7]  = '{F_DIVU,  32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, DIV_CYC, "divu_by_zero"};
        vecs[8]  = '{F_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DIV_CYC, "div_7_m2"};
        vecs[9]  = '{F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MUL_CYC, "mult_min_sq"};
        vecs[10] = '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_CYC, "multu_max_sq"};
        vecs[11] = '{F_DIV,   32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF, DIV_CYC, "div_neg_by_zero"};
        vecs[12] = '{F_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, MUL_CYC, "mult_m3x5"};
        vecs[13] = '{F_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, DIV_CYC, "divu_100_7"};

        reset       = 1'b0;
        op_valid    = 1'b0;
        function_in = F_ADD;
        operand_a   = '0;
        operand_b   = '0;

        #12;
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_stall", {31'b0, stall_req}, 32'h0);
        chk("reset_hi", hi_out, 32'h0);
        chk("reset_lo", lo_out, 32'h0);
        chk("reset_result", result_out, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // MT then MF while idle: no stall, value visible next cycle
        issue(F_MTHI, 32'hAAAA5555, 32'h0);
        @(negedge clk);
        op_valid    = 1'b1;
        function_in = F_MFHI;
        #1;
        chk("mthi_mfhi_result", result_out, 32'hAAAA5555);
        chk("mthi_mfhi_stall", {31'b0, stall_req}, 32'h0);
        op_valid = 1'b0;
        issue(F_MTLO, 32'h13579BDF, 32'h0);
        @(negedge clk);
        op_valid    = 1'b1;
        function_in = F_MFLO;
        #1;
        chk("mtlo_mflo_result", result_out, 32'h13579BDF);
        chk("mtlo_hi_kept", hi_out, 32'hAAAA5555);
        op_valid    = 1'b0;
        function_in = F_ADD;
        #1;
        chk("no_mf_result_zero", result_out, 32'h0);

        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].funct, vecs[i].a, vecs[i].b);
            wait_idle(cyc);
            chk($sformatf("%s busy_cycles", vecs[i].name), 32'(cyc), 32'(vecs[i].cyc));
            chk($sformatf("%s hi", vecs[i].name), hi_out, vecs[i].hi);
            chk($sformatf("%s lo", vecs[i].name), lo_out, vecs[i].lo);
            op_valid    = 1'b1;
            function_in = F_MFHI;
            #1;
            chk($sformatf("%s mfhi", vecs[i].name), result_out, vecs[i].hi);
            function_in = F_MFLO;
            #1;
            chk($sformatf("%s mflo", vecs[i].name), result_out, vecs[i].lo);
            op_valid    = 1'b0;
            function_in = F_ADD;
        end

        // Interlock: MFLO held right behind MULT stalls until the product lands
        @(negedge clk);
        op_valid    = 1'b1;
        function_in = F_MULT;
        operand_a   = 32'd6;
        operand_b   = 32'd7;
        @(posedge clk);
        #1;
        function_in = F_MFLO;
        cyc = 0;
        @(negedge clk);
        while (stall_req && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        chk("interlock_stall_cycles", 32'(cyc), 32'(MUL_CYC));
        chk("interlock_busy_after", {31'b0, busy}, 32'h0);
        chk("interlock_mflo", result_out, 32'd42);
        op_valid    = 1'b0;
        function_in = F_ADD;

        // Unrelated funct does not stall; a held start while busy is never taken
        issue(F_DIVU, 32'd100, 32'd7);
        @(negedge clk);
        op_valid    = 1'b1;
        function_in = F_ADD;
        #1;
        chk("busy_add_stall", {31'b0, stall_req}, 32'h0);
        chk("busy_add_busy", {31'b0, busy}, 32'h1);
        function_in = F_MULTU;
        operand_a   = 32'd5;
        operand_b   = 32'd5;
        #1;
        chk("busy_multu_stall", {31'b0, stall_req}, 32'h1);
        repeat (5) @(negedge clk);
        op_valid    = 1'b0;
        function_in = F_ADD;
        wait_idle(cyc);
        chk("busy_start_ignored_lo", lo_out, 32'd14);
        chk("busy_start_ignored_hi", hi_out, 32'd2);

        // Async reset mid-RUN discards the operation and clears HI/LO
        issue(F_MULT, 32'hFFFFFFFE, 32'h00000003);
        repeat (10) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("midrun_reset_busy", {31'b0, busy}, 32'h0);
        chk("midrun_reset_hi", hi_out, 32'h0);
        chk("midrun_reset_lo", lo_out, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        op_valid    = 1'b1;
        function_in = F_MFLO;
        #1;
        chk("midrun_reset_mflo", result_out, 32'h0);
        chk("midrun_reset_still_idle", {31'b0, busy}, 32'h0);
        op_valid    = 1'b0;
        function_in = F_ADD;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
